// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_pkg
// Description : Shared types and default widths for the data-memory arbiter.
// Revision    : 1.0
// ============================================================================
package dm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int c_def_aw        = 8;
  localparam int c_def_dw        = 8;
  localparam int c_def_max_burst = 4;

  function automatic owner_t port_to_owner(input logic port);
    return port ? OWN_P1 : OWN_P0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_if
// Description : Requester-side and dm-side signals of the data-memory arbiter.
// Revision    : 1.0
// ============================================================================
interface dm_arb_if import dm_arb_pkg::*; #(
  parameter int AW = c_def_aw,
  parameter int DW = c_def_dw
) ();

  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin pick with burst retention.
// Revision    : 1.0
// ============================================================================
module rr_pick2 import dm_arb_pkg::*; (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  owner_t     i_owner,
  input  logic       i_burst_ok,
  output owner_t     o_winner
);

  always_comb begin
    o_winner = OWN_NONE;
    // The owner keeps the memory unless the other side waits and the burst is spent.
    if (i_owner == OWN_P0 && i_req[0] && (!i_req[1] || i_burst_ok)) begin
      o_winner = OWN_P0;
    end else if (i_owner == OWN_P1 && i_req[1] && (!i_req[0] || i_burst_ok)) begin
      o_winner = OWN_P1;
    end else if (i_req == 2'b11) begin
      o_winner = port_to_owner(!i_last);
    end else if (i_req[0]) begin
      o_winner = OWN_P0;
    end else if (i_req[1]) begin
      o_winner = OWN_P1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin, burst-bounded sharing of single-port dm between
//               the core LSU (port 0) and the debug/loader port (port 1).
// Revision    : 1.0
// ============================================================================
module dm_arbiter import dm_arb_pkg::*; #(
  parameter int AW        = c_def_aw,
  parameter int DW        = c_def_dw,
  parameter int MAX_BURST = c_def_max_burst
) (
  input  logic      clk,
  input  logic      reset,
  dm_arb_if.slave   bus
);

  localparam int                 c_cnt_w   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_BURST - 1);

  owner_t               owner_q, owner_d;
  logic                 last_q, last_d;
  logic [c_cnt_w-1:0]   burst_cnt_q, burst_cnt_d;
  logic [1:0]           rd_pend_q, rd_pend_d;

  owner_t               w_winner;
  logic                 w_burst_ok;
  logic [1:0]           w_req;
  logic [1:0]           w_gnt;
  logic                 w_mem_en;
  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_addr;
  logic [DW-1:0]        w_mem_wdata;

  // Requests are masked while reset is held so no access leaks out during reset.
  assign w_req      = reset ? bus.req : 2'b00;
  assign w_burst_ok = (burst_cnt_q < c_cnt_max);

  rr_pick2 u_pick (
    .i_req      (w_req),
    .i_last     (last_q),
    .i_owner    (owner_q),
    .i_burst_ok (w_burst_ok),
    .o_winner   (w_winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      rd_pend_q   <= 2'b00;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  always_comb begin
    owner_d     = OWN_NONE;
    last_d      = last_q;
    burst_cnt_d = '0;
    if (w_winner != OWN_NONE) begin
      owner_d = w_winner;
      last_d  = (w_winner == OWN_P1);
      if (w_winner == owner_q) begin
        burst_cnt_d = (burst_cnt_q == c_cnt_max) ? burst_cnt_q
                                                 : burst_cnt_q + c_cnt_w'(1);
      end
    end
    rd_pend_d = w_gnt & ~bus.we;
  end

  always_comb begin
    w_gnt       = 2'b00;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (w_winner)
      OWN_P0: begin
        w_gnt       = 2'b01;
        w_mem_en    = 1'b1;
        w_mem_we    = bus.we[0];
        w_mem_addr  = bus.addr0;
        w_mem_wdata = bus.wdata0;
      end
      OWN_P1: begin
        w_gnt       = 2'b10;
        w_mem_en    = 1'b1;
        w_mem_we    = bus.we[1];
        w_mem_addr  = bus.addr1;
        w_mem_wdata = bus.wdata1;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = w_gnt;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.busy      = (owner_q != OWN_NONE);
  assign bus.rvalid    = rd_pend_q;
  assign bus.rdata     = (|rd_pend_q) ? bus.mem_rdata : '0;

  // A waiting requester must hold its request and command until granted.
  a_p0_hold: assert property (@(posedge clk) disable iff (!reset)
    (bus.req[0] && !bus.gnt[0]) |=>
      (bus.req[0] && $stable(bus.we[0]) && $stable(bus.addr0) && $stable(bus.wdata0)));

  a_p1_hold: assert property (@(posedge clk) disable iff (!reset)
    (bus.req[1] && !bus.gnt[1]) |=>
      (bus.req[1] && $stable(bus.we[1]) && $stable(bus.addr1) && $stable(bus.wdata1)));

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Scoreboard bench for dm_arbiter with a behavioural sync dm.
// Revision    : 1.0
// ============================================================================
module tb_dm_arbiter;

  typedef struct {
    logic [1:0] gnt;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } gnt_t;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
  } rd_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gnt_t exp_gnt[$];
  rd_t  exp_rd[$];

  logic [7:0] mem [256];
  logic [7:0] mem_rd_q;

  dm_arb_if #(.AW(8), .DW(8)) bus ();

  dm_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rd_q = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd_q          <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rd_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic [7:0] a1, input logic [7:0] d1);
    bus.req    = req;
    bus.we     = we;
    bus.addr0  = a0;
    bus.wdata0 = d0;
    bus.addr1  = a1;
    bus.wdata1 = d1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  function automatic void exp_g(input logic [1:0] g, input logic w,
                                input logic [7:0] a, input logic [7:0] d);
    gnt_t e;
    e.gnt = g; e.we = w; e.addr = a; e.wdata = d;
    exp_gnt.push_back(e);
  endfunction

  function automatic void exp_r(input logic [1:0] p, input logic [7:0] d);
    rd_t r;
    r.port = p; r.data = d;
    exp_rd.push_back(r);
  endfunction

  // Monitor: every presented grant and read return is matched against the queues.
  always @(negedge clk) begin : mon
    gnt_t e;
    rd_t  r;
    if (bus.gnt != 2'b00) begin
      if (exp_gnt.size() == 0) begin
        checks++; errors++;
        $display("FAIL gnt_unexpected: got %0b expected none at %0t", bus.gnt, $time);
      end else begin
        e = exp_gnt.pop_front();
        chk("gnt",       {30'd0, bus.gnt},   {30'd0, e.gnt});
        chk("mem_en",    {31'd0, bus.mem_en}, 32'd1);
        chk("mem_we",    {31'd0, bus.mem_we}, {31'd0, e.we});
        chk("mem_addr",  {24'd0, bus.mem_addr},  {24'd0, e.addr});
        chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.wdata});
      end
    end else begin
      chk("idle_mem_strobes", {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
    end
    if (bus.rvalid != 2'b00) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: got %0b expected none at %0t", bus.rvalid, $time);
      end else begin
        r = exp_rd.pop_front();
        chk("rvalid", {30'd0, bus.rvalid}, {30'd0, r.port});
        chk("rdata",  {24'd0, bus.rdata},  {24'd0, r.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",       {30'd0, bus.gnt},    32'd0);
    chk("rst_rvalid",    {30'd0, bus.rvalid}, 32'd0);
    chk("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},   32'd0);
    chk("rst_mem_addr",  {24'd0, bus.mem_addr},  32'd0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    chk("rst_rdata",     {24'd0, bus.rdata},     32'd0);
    reset = 1'b1;

    // P0 write then read of address 0x00
    drive(2'b01, 2'b01, 8'h00, 8'h07, 8'h00, 8'h00); exp_g(2'b01, 1'b1, 8'h00, 8'h07); cyc();
    drive(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); exp_g(2'b01, 1'b0, 8'h00, 8'h00);
    exp_r(2'b01, 8'h07); cyc();
    idle(); cyc(); cyc();

    // P1 preload while P0 idle, then P0 reads back
    drive(2'b10, 2'b10, 8'h00, 8'h00, 8'h00, 8'h80); exp_g(2'b10, 1'b1, 8'h00, 8'h80); cyc();
    drive(2'b10, 2'b10, 8'h00, 8'h00, 8'h01, 8'h05); exp_g(2'b10, 1'b1, 8'h01, 8'h05); cyc();
    idle(); cyc();
    drive(2'b01, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00); exp_g(2'b01, 1'b0, 8'h01, 8'h00);
    exp_r(2'b01, 8'h05); cyc();
    idle(); cyc(); cyc();

    // Both requesting from reset: P0 x4, P1 x4, P0 x4, then P1 finishes
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("busy_after_reset", {31'd0, bus.busy}, 32'd0);
    drive(2'b11, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) begin
      if ((i / 4) == 1) begin exp_g(2'b10, 1'b0, 8'h00, 8'h00); exp_r(2'b10, 8'h80); end
      else              begin exp_g(2'b01, 1'b0, 8'h01, 8'h00); exp_r(2'b01, 8'h05); end
    end
    exp_g(2'b10, 1'b0, 8'h00, 8'h00); exp_r(2'b10, 8'h80);
    repeat (2) cyc();
    chk("busy_in_burst", {31'd0, bus.busy}, 32'd1);
    repeat (10) cyc();
    drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); cyc();
    idle(); cyc();
    chk("busy_after_idle", {31'd0, bus.busy}, 32'd0);
    cyc();

    // P1 lone burst of 6 reads saturates, then P0 takes over immediately
    drive(2'b10, 2'b10, 8'h00, 8'h00, 8'h05, 8'h3C); exp_g(2'b10, 1'b1, 8'h05, 8'h3C); cyc();
    idle(); cyc();
    drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h05, 8'h00);
    for (int i = 0; i < 6; i++) begin exp_g(2'b10, 1'b0, 8'h05, 8'h00); exp_r(2'b10, 8'h3C); end
    repeat (6) cyc();
    drive(2'b11, 2'b00, 8'h00, 8'h00, 8'h05, 8'h00);
    for (int i = 0; i < 4; i++) begin exp_g(2'b01, 1'b0, 8'h00, 8'h00); exp_r(2'b01, 8'h80); end
    exp_g(2'b10, 1'b0, 8'h05, 8'h00); exp_r(2'b10, 8'h3C);
    repeat (4) cyc();
    drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h05, 8'h00); cyc();
    idle(); cyc(); cyc();

    // Alternating single-cycle requests with write-then-read
    drive(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); exp_g(2'b01, 1'b0, 8'h00, 8'h00);
    exp_r(2'b01, 8'h80); cyc();
    drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h01, 8'h00); exp_g(2'b10, 1'b0, 8'h01, 8'h00);
    exp_r(2'b10, 8'h05); cyc();
    drive(2'b01, 2'b01, 8'h02, 8'h5A, 8'h00, 8'h00); exp_g(2'b01, 1'b1, 8'h02, 8'h5A); cyc();
    drive(2'b01, 2'b00, 8'h02, 8'h00, 8'h00, 8'h00); exp_g(2'b01, 1'b0, 8'h02, 8'h00);
    exp_r(2'b01, 8'h5A); cyc();
    idle(); cyc(); cyc();

    // Reset right after a read grant drops its rvalid; P0 wins first afterwards
    drive(2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); exp_g(2'b01, 1'b0, 8'h00, 8'h00); cyc();
    reset = 1'b0;
    drive(2'b11, 2'b00, 8'h00, 8'h00, 8'h01, 8'h00);
    @(negedge clk);
    chk("rst_mid_rvalid", {30'd0, bus.rvalid}, 32'd0);
    chk("rst_mid_gnt",    {30'd0, bus.gnt},    32'd0);
    chk("rst_mid_busy",   {31'd0, bus.busy},   32'd0);
    cyc(); cyc();
    reset = 1'b1;
    exp_g(2'b01, 1'b0, 8'h00, 8'h00); exp_r(2'b01, 8'h80); cyc();
    drive(2'b10, 2'b00, 8'h00, 8'h00, 8'h01, 8'h00);
    exp_g(2'b10, 1'b0, 8'h01, 8'h00); exp_r(2'b10, 8'h05); cyc();
    idle(); repeat (3) cyc();

    chk("gnt_queue_drained", exp_gnt.size(), 32'd0);
    chk("rd_queue_drained",  exp_rd.size(),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (dm) between two requesters: port 0 = core load/store unit, port 1 = debug/loader port (bench preload, post-run readback).
- Round-robin arbitration with bounded bursts: the current owner keeps the memory while requesting, up to MAX_BURST consecutive grants.
- Sits between the core/debug masters and dm; dm is a synchronous RAM with 1-cycle read latency.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; held with cmd fields stable until gnt.
- we  in  2  per-port write enable (1=store, 0=load).
- addr0, addr1  in  AW each  per-port address.
- wdata0, wdata1  in  DW each  per-port write data.
- gnt  out  2  one-hot or zero; access issued this cycle.
- rvalid  out  2  read data valid, 1 cycle after a read grant.
- rdata  out  DW  read data (shared; qualified by rvalid).
- mem_en  out  1  dm access strobe.
- mem_we  out  1  dm write strobe.
- mem_addr  out  AW  dm address.
- mem_wdata  out  DW  dm write data.
- mem_rdata  in  DW  dm read data, valid 1 cycle after mem_en && !mem_we.
- busy  out  1  owner != NONE.

Behaviour:
- State: owner ∈ {NONE, P0, P1}, last (last granted port), burst_cnt (counts 0..MAX_BURST-1), rd_pend[1:0].
- Reset (reset=0, async): owner=NONE, last=P1 (P0 wins the first tie), burst_cnt=0, rd_pend=0. Outputs gnt=0, rvalid=0, mem_en=0, mem_we=0, busy=0. mem_addr, mem_wdata, and rdata are 0.
- Grant decision (combinational, same cycle as req):
  - Winner is the owner if the owner's req=1 and (the other req=0 or burst_cnt < MAX_BURST-1).
  - Otherwise, if both req=1, winner is the port != last.
  - Otherwise, winner is whichever req=1.
  - No req: no grant.
- gnt[w]=1, mem_en=1, and mem_we/mem_addr/mem_wdata are muxed from winner w; all zero when there is no grant.
- At clk edge on a grant:
  - If w==owner, burst_cnt++, saturating at MAX_BURST-1.
  - If w!=owner, owner=w and burst_cnt=0.
  - last=w in both cases.
- At clk edge with no grant: owner=NONE, burst_cnt=0.
- Owner drops req: the other port may win in the same cycle; no idle bubble.
- Burst with the other port idle: the owner is never preempted; burst_cnt saturates.
- Reads:
  - rd_pend[w] is set at the edge after a read grant.
  - rvalid = rd_pend (registered); rdata = mem_rdata.
  - Back-to-back reads from alternating ports are legal; exactly one rvalid per read grant.
- Writes produce no rvalid. Write-then-read of the same address in consecutive grants returns the new data (dm write-first is not required; the grants are in different cycles).
- Throughput: one access per cycle maximum; a lone requester gets gnt every cycle.
- Reset mid-operation: pending rvalid is dropped (not delivered) and arbitration restarts with P0 priority.
- Requester protocol violations (cmd fields change before gnt) are undefined; assertions flag them in simulation.

Decomposition:
- Package dm_arb_pkg: owner_t enum {OWN_NONE, OWN_P0, OWN_P1}, default AW/DW constants.
- Sub-module rr_pick2: pure combinational two-way round-robin pick (inputs req, last, owner, burst_ok; output winner). Everything else lives in dm_arbiter.

Test Plan:
- Reset then P0 write addr 0x00 data 0x07, then P0 read addr 0x00 → gnt=01 each cycle; rvalid=01 one cycle after the read; rdata=0x07.
- Both req continuously from reset, MAX_BURST=4, all reads → grant pattern P0×4, P1×4, P0×4; each rvalid one cycle after its gnt; no cycle without a grant.
- P1 alone reads 0x05 for 6 cycles → 6 consecutive gnt=10, burst_cnt saturates at 3, no preemption. P0 then asserts → P1 keeps the grant for 0 further cycles; P0 is granted on the next cycle.
- Preload by P1 writing 0x80 to addr 0x00 and 0x05 to addr 0x01 while P0 is idle, then P0 reads 0x01 → rdata=0x05; mem_we is high only during the two write grants.
- Assert reset in the cycle after a P0 read grant → rvalid stays 0. After release with both req: first gnt=01; busy=0 while reset is low.
- Alternating single-cycle reqs (P0 read, P1 read, P0 write) → gnt 01, 10, 01 in consecutive cycles; rvalid 01 then 10; no rvalid for the write.
